// File: rtl/vov_frame_collector.sv
// vov_frame_collector
//
// Downstream consumer of the IPV reducer's vov output. It follows the
// reducer's fixed output phase from reset, samples each valid K-bit vov word,
// packs W consecutive words into a frame, and queues complete frames in a
// first-word-fall-through FIFO for a valid/ready consumer. A frame that
// completes while the FIFO is full (with no pop on the same edge) is dropped
// and the sticky overflow flag is raised.
//
// Optional feature macro: VOV_FRAME_COLLECTOR_POPCNT_EN
//   defined   : ones count of each frame is stored with it and shown on out_pop
//   undefined : no popcount logic, out_pop is tied to 0
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   vov        in   reducer output word, meaningful only on sample edges
//   clr        in   synchronous flush of FIFO, frame assembly and overflow
//   out_valid  out  FIFO non-empty
//   out_ready  in   consumer accepts the head frame
//   out_data   out  head frame, word 0 in the low K bits
//   out_pop    out  ones count of the head frame
//   fill       out  number of frames queued
//   overflow   out  sticky: a completed frame was dropped
module vov_frame_collector #(
  parameter int K     = 4,
  parameter int STALL = 3,
  parameter int W     = 4,
  parameter int DEPTH = 4,
  localparam int FRAME_W = W * K,
  localparam int POP_W   = $clog2(FRAME_W + 1),
  localparam int FILL_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [K-1:0]       vov,
  input  logic               clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FRAME_W-1:0] out_data,
  output logic [POP_W-1:0]   out_pop,
  output logic [FILL_W-1:0]  fill,
  output logic               overflow
);

  localparam int PH_W  = $clog2(K + STALL);
  localparam int IDX_W = $clog2(W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [FILL_W-1:0] FULL_LEVEL = FILL_W'(DEPTH);

  // Phase tracker: a lead-in of K+STALL edges, then one sample every K edges.
  // It is only cleared by rst_n because the reducer ignores clr.
  typedef enum logic {PH_LEAD, PH_STEADY} phase_t;

  phase_t           ph_state, ph_state_nx;
  logic [PH_W-1:0]  ph_cnt, ph_cnt_nx;
  logic             sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_state <= PH_LEAD;
      ph_cnt   <= '0;
    end else begin
      ph_state <= ph_state_nx;
      ph_cnt   <= ph_cnt_nx;
    end
  end

  // sample is high during the cycle whose closing edge is a sample edge.
  always_comb begin
    ph_state_nx = ph_state;
    ph_cnt_nx   = ph_cnt + PH_W'(1);
    sample      = 1'b0;
    case (ph_state)
      PH_LEAD: begin
        if (ph_cnt == PH_W'(K + STALL - 1)) begin
          sample      = 1'b1;
          ph_cnt_nx   = '0;
          ph_state_nx = PH_STEADY;
        end
      end
      PH_STEADY: begin
        if (ph_cnt == PH_W'(K - 1)) begin
          sample    = 1'b1;
          ph_cnt_nx = '0;
        end
      end
      default: begin
        ph_state_nx = PH_LEAD;
        ph_cnt_nx   = '0;
      end
    endcase
  end

  // Frame assembly: words 0..W-2 wait in slots; the last word goes straight
  // into the pushed frame together with the stored slots.
  logic [IDX_W-1:0]       word_idx;
  logic [(W-1)*K-1:0]     slots;
  logic [FRAME_W-1:0]     frame;
  logic                   last_word;
  logic                   push_req;

  assign last_word = (word_idx == IDX_W'(W - 1));
  assign frame     = {vov, slots};
  assign push_req  = sample && last_word && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx <= '0;
      slots    <= '0;
    end else if (clr) begin
      word_idx <= '0;
    end else if (sample) begin
      if (last_word) begin
        word_idx <= '0;
      end else begin
        word_idx <= word_idx + IDX_W'(1);
        for (int i = 0; i < W - 1; i++) begin
          if (word_idx == IDX_W'(i)) slots[i*K +: K] <= vov;
        end
      end
    end
  end

  // FIFO control: a full FIFO still accepts a push when the head is popped
  // on the same edge, so the level stays unchanged.
  logic [FRAME_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic               full, pop, push_ok, drop;

  assign full      = (fill == FULL_LEVEL);
  assign out_valid = (fill != '0);
  assign pop       = out_valid && out_ready && !clr;
  assign push_ok   = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fill     <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fill     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= frame;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // Head frame is shown only while valid so an empty FIFO presents zeros.
  assign out_data = out_valid ? mem[rd_ptr] : '0;

`ifdef VOV_FRAME_COLLECTOR_POPCNT_EN
  // Ones count is computed once at push time and travels with the frame.
  logic [POP_W-1:0] pop_mem [DEPTH];
  logic [POP_W-1:0] frame_pop;

  always_comb begin
    frame_pop = '0;
    for (int i = 0; i < FRAME_W; i++) frame_pop = frame_pop + POP_W'(frame[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pop_mem[i] <= '0;
    end else if (!clr && push_ok) begin
      pop_mem[wr_ptr] <= frame_pop;
    end
  end

  assign out_pop = out_valid ? pop_mem[rd_ptr] : '0;
`else
  assign out_pop = '0;
`endif

endmodule

// File: doc/vov_frame_collector.md
# vov_frame_collector

Downstream consumer of the IPV reducer's `vov` output. It tracks the reducer's fixed output phase from reset, samples each valid k-bit `vov` word, and packs W consecutive words into a frame. Completed frames are queued in a small first-word-fall-through FIFO and delivered to the next stage over a valid/ready handshake. Frames that arrive while the FIFO is full are dropped and flagged.

## Interface
- `K`, 4, bits per `vov` word; must match the reducer's k (2..8)
- `STALL`, 3, reducer output pipeline depth; must match the reducer's stall_cycle
- `W`, 4, `vov` words per frame (≥2)
- `DEPTH`, 4, FIFO depth in frames; power of 2, ≥2
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `vov`  in  K  reducer output word; meaningful only on sample edges
- `clr`  in  1  synchronous flush: empties FIFO, restarts frame assembly, clears `overflow`
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts head frame
- `out_data`  out  W*K  head frame; word 0 in [K-1:0]
- `out_pop`  out  $clog2(W*K+1)  ones count of head frame (see Configuration)
- `fill`  out  $clog2(DEPTH)+1  frames currently queued
- `overflow`  out  1  sticky: a completed frame was dropped

## Operation
- Phase tracker: counts rising edges after reset release. Sample edges are edge K+STALL, then every K edges (mK+STALL, m≥1). `vov` on all other edges is ignored.
- Phase tracker is cleared only by `rst_n`, never by `clr`, because the reducer is not cleared by `clr`.
- Frame assembly:
  - A word index runs 0..W-1.
  - Sample with index < W-1: store `vov` in slot [index], then increment the index.
  - Sample with index = W-1: form the frame {vov, slots W-2..0}, push it to the FIFO, and set the index to 0.
  - Slots are not cleared between frames.
- FIFO:
  - First-word fall-through; `out_valid` = (`fill` != 0).
  - Pop when `out_valid && out_ready`.
  - Push is accepted if not full, or if full and a pop occurs on the same edge (fill unchanged).
  - Otherwise the frame is dropped and `overflow` is set.
- `out_ready` while `out_valid`=0: no effect.
- `clr` has priority over push, pop and sample on the same edge. It sets fill=0, word index=0 and `overflow`=0. The `vov` sample on that edge is discarded.
- Reset values: `out_valid`=0, `out_data`=0, `out_pop`=0, `fill`=0, `overflow`=0, word index=0, phase tracker=0.
- Reset asserted mid-frame or mid-drain: all state is cleared asynchronously, and the phase restarts from edge 0 after release.

## Timing
- A frame is pushed on the sample edge of its last word. `out_valid`, `out_data`, `out_pop` and `fill` reflect it directly after that edge, with zero added latency, when the FIFO was empty.
- First possible `out_valid` is after edge (W-1)·K+K+STALL; defaults give edge 19.
- Pop takes effect on the edge where `out_valid && out_ready`. The next frame is presented directly after that edge.
- Sustained rate: one frame per W·K cycles. Consumer stalls are absorbed up to DEPTH frames.
- `overflow` rises on the dropping edge and holds until `clr` or reset.

## Configuration
- `VOV_FRAME_COLLECTOR_POPCNT_EN` defined:
  - The ones count of each frame is computed at push time and stored in the FIFO alongside the frame.
  - `out_pop` presents the count for the head frame, with the same timing as `out_data`.
- Not defined:
  - No popcount logic or storage.
  - `out_pop` is tied to 0; the port remains present.

## Test plan
- Defaults, `out_ready`=1. Drive `vov` = 0x1, 0x2, 0x3, 0x4 on sample edges 7, 11, 15, 19 and 0xF on every other edge -> `out_valid` high after edge 19 with `out_data`=0x4321, `fill`=1; the frame is popped on edge 20 and `fill`=0.
- `out_ready`=0, five frames of 0x1111·n (n=1..5) -> `fill`=4 after the 4th frame. The 5th frame is dropped and `overflow`=1. Draining yields 0x1111, 0x2222, 0x3333, 0x4444 in order.
- FIFO full and `out_ready`=1 on the push edge of a new frame 0xAAAA -> pop and push on the same edge, `fill` stays 4, `overflow` stays 0, and 0xAAAA is the last frame out.
- Assert `clr` for one cycle after 2 words of a frame while `overflow`=1 and `fill`=3 -> `fill`=0, `overflow`=0, `out_valid`=0. The next sample is stored as word 0, and the following frame completes 4 sample edges later with correct content.
- Assert `rst_n` low mid-frame, then release -> all outputs 0 and the first sample lands on edge 7 after release.
- With `VOV_FRAME_COLLECTOR_POPCNT_EN`: frame 0xFFFF gives `out_pop`=16 and frame 0x0101 gives `out_pop`=2. Without the macro, `out_pop`=0 for both.
